// File: rtl/brew_cycle_sequencer.sv
// Per-drink brew sequencer: preheat, pre-infusion and brew phases on a ms
// timebase, driving the water temperature/pressure controller and the pump.
module brew_cycle_sequencer #(
    parameter int TICK_CYCLES     = 50_000,
    parameter int HEAT_TIMEOUT_MS = 30_000,
    parameter int PREINFUSE_MS    = 2_000,
    parameter int BREW_MS_STD     = 20_000,
    parameter int BREW_MS_LARGE   = 30_000,
    parameter int TEMP_DROP_MS    = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cancel,
    input  logic       fault_clear,
    input  logic       keep_warm,
    input  logic       extra_hot,
    input  logic       large_size,
    input  logic       temp_ready,
    input  logic       pressure_ready,
    output logic       heating_enable,
    output logic       brewing_active,
    output logic [1:0] target_temp_mode,
    output logic       pump_enable,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREHEAT   = 3'd1,
        PREINFUSE = 3'd2,
        BREW      = 3'd3,
        COMPLETE  = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [15:0] HEAT_LIM   = 16'(HEAT_TIMEOUT_MS);
    localparam logic [15:0] PRE_LIM    = 16'(PREINFUSE_MS);
    localparam logic [15:0] STD_LIM    = 16'(BREW_MS_STD);
    localparam logic [15:0] LARGE_LIM  = 16'(BREW_MS_LARGE);
    localparam logic [15:0] DROP_LIM   = 16'(TEMP_DROP_MS);

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic [15:0]   ms;
    logic [15:0]   drop;
    logic [15:0]   brew_lim;
    logic          tick;
    logic          extra_q;
    logic          large_q;
    logic          opt_load;
    logic          extra_d;
    logic [1:0]    code_d;
    logic [1:0]    hot_mode;

    logic       heat_d;
    logic       brew_d;
    logic [1:0] mode_d;
    logic       pump_d;
    logic       busy_d;
    logic       done_d;
    logic       fault_d;

    assign tick      = (presc == PRESC_MAX);
    assign brew_lim  = large_q ? LARGE_LIM : STD_LIM;
    assign opt_load  = (state == IDLE) && start && !cancel;
    assign extra_d   = opt_load ? extra_hot : extra_q;
    assign hot_mode  = extra_d ? 2'b10 : 2'b01;
    assign state_out = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cancel beats pressure loss, which beats temp drop, which beats timers.
    always_comb begin
        next_state = state;
        code_d     = fault_code;
        unique case (state)
            IDLE: begin
                if (start && !cancel) next_state = PREHEAT;
            end
            PREHEAT: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (temp_ready && pressure_ready) begin
                    next_state = PREINFUSE;
                end else if (ms == HEAT_LIM) begin
                    next_state = FAULT;
                    code_d     = 2'b01;
                end
            end
            PREINFUSE: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (!pressure_ready) begin
                    next_state = FAULT;
                    code_d     = 2'b10;
                end else if (ms == PRE_LIM) begin
                    next_state = BREW;
                end
            end
            BREW: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (!pressure_ready) begin
                    next_state = FAULT;
                    code_d     = 2'b10;
                end else if (drop == DROP_LIM) begin
                    next_state = FAULT;
                    code_d     = 2'b11;
                end else if (ms == brew_lim) begin
                    next_state = COMPLETE;
                end
            end
            COMPLETE: begin
                next_state = IDLE;
            end
            FAULT: begin
                if (fault_clear) begin
                    next_state = IDLE;
                    code_d     = 2'b00;
                end
            end
            default: begin
                next_state = IDLE;
                code_d     = 2'b00;
            end
        endcase
    end

    // Outputs follow the state being entered so they change on the same edge.
    always_comb begin
        heat_d  = 1'b0;
        brew_d  = 1'b0;
        mode_d  = 2'b00;
        pump_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        unique case (next_state)
            IDLE: begin
                heat_d = keep_warm;
            end
            PREHEAT: begin
                heat_d = 1'b1;
                mode_d = hot_mode;
                busy_d = 1'b1;
            end
            PREINFUSE, BREW: begin
                heat_d = 1'b1;
                mode_d = hot_mode;
                pump_d = 1'b1;
                brew_d = 1'b1;
                busy_d = 1'b1;
            end
            COMPLETE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                heat_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            ms    <= '0;
            drop  <= '0;
        end else if (next_state != state) begin
            presc <= '0;
            ms    <= '0;
            drop  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) ms <= ms + 16'd1;
            if (state != BREW || temp_ready) begin
                drop <= '0;
            end else if (tick) begin
                drop <= drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            extra_q <= 1'b0;
            large_q <= 1'b0;
        end else if (opt_load) begin
            extra_q <= extra_hot;
            large_q <= large_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heating_enable   <= 1'b0;
            brewing_active   <= 1'b0;
            target_temp_mode <= 2'b00;
            pump_enable      <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
            fault_code       <= 2'b00;
        end else begin
            heating_enable   <= heat_d;
            brewing_active   <= brew_d;
            target_temp_mode <= mode_d;
            pump_enable      <= pump_d;
            busy             <= busy_d;
            done             <= done_d;
            fault            <= fault_d;
            fault_code       <= code_d;
        end
    end

endmodule

// File: tb/tb_brew_cycle_sequencer.sv
// Directed bench for brew_cycle_sequencer: a vector table for single-step
// behaviour plus hand-written multi-cycle sequences.
module tb_brew_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       fault_clear = 1'b0;
    logic       keep_warm = 1'b0;
    logic       extra_hot = 1'b0;
    logic       large_size = 1'b0;
    logic       temp_ready = 1'b0;
    logic       pressure_ready = 1'b0;
    logic       heating_enable;
    logic       brewing_active;
    logic [1:0] target_temp_mode;
    logic       pump_enable;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state_out;

    brew_cycle_sequencer #(
        .TICK_CYCLES    (10),
        .HEAT_TIMEOUT_MS(50),
        .PREINFUSE_MS   (3),
        .BREW_MS_STD    (8),
        .BREW_MS_LARGE  (12),
        .TEMP_DROP_MS   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cancel          (cancel),
        .fault_clear     (fault_clear),
        .keep_warm       (keep_warm),
        .extra_hot       (extra_hot),
        .large_size      (large_size),
        .temp_ready      (temp_ready),
        .pressure_ready  (pressure_ready),
        .heating_enable  (heating_enable),
        .brewing_active  (brewing_active),
        .target_temp_mode(target_temp_mode),
        .pump_enable     (pump_enable),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .fault_code      (fault_code),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    // in  = {start,cancel,fault_clear,keep_warm,extra_hot,large,temp,press}
    // exp = {state,heat,brewing,mode,pump,busy,done,fault,code}
    typedef struct packed {
        logic [7:0]  in;
        logic [12:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    function automatic logic [12:0] outs();
        return {state_out, heating_enable, brewing_active, target_temp_mode,
                pump_enable, busy, done, fault, fault_code};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (state_out == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        start = 0; cancel = 0; fault_clear = 0; keep_warm = 0;
        extra_hot = 0; large_size = 0; temp_ready = 0; pressure_ready = 0;
    endtask

    task automatic clear_fault();
        fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        pressure_ready = 1'b1;
        temp_ready = 1'b1;
    endtask

    // Leaves the bench just after the edge that enters BREW.
    task automatic go_brew(input logic lg);
        bit ok;
        extra_hot = 0; large_size = lg;
        temp_ready = 1; pressure_ready = 1;
        start = 1;
        step(1);
        start = 0;
        wait_state(3'd3, 100, ok);
        check("brew_entry", ok, 1);
    endtask

    initial begin
        bit ok;
        int c0;
        int d0;
        int pcount;
        logic [1:0] brew_mode;

        vecs[0]  = {8'b0000_0000, 13'b000_0_0_00_0_0_0_0_00};
        vecs[1]  = {8'b0001_0000, 13'b000_1_0_00_0_0_0_0_00};
        vecs[2]  = {8'b1100_0000, 13'b000_0_0_00_0_0_0_0_00};
        vecs[3]  = {8'b0010_0000, 13'b000_0_0_00_0_0_0_0_00};
        vecs[4]  = {8'b1000_0000, 13'b001_1_0_01_0_1_0_0_00};
        vecs[5]  = {8'b0000_0010, 13'b001_1_0_01_0_1_0_0_00};
        vecs[6]  = {8'b0000_0011, 13'b010_1_1_01_1_1_0_0_00};
        vecs[7]  = {8'b0100_0011, 13'b000_0_0_00_0_0_0_0_00};
        vecs[8]  = {8'b1000_1100, 13'b001_1_0_10_0_1_0_0_00};
        vecs[9]  = {8'b0100_0000, 13'b000_0_0_00_0_0_0_0_00};
        vecs[10] = {8'b1000_0011, 13'b001_1_0_01_0_1_0_0_00};
        vecs[11] = {8'b0000_0011, 13'b010_1_1_01_1_1_0_0_00};
        vecs[12] = {8'b0010_0011, 13'b010_1_1_01_1_1_0_0_00};
        vecs[13] = {8'b0000_0010, 13'b101_0_0_00_0_0_0_1_10};
        vecs[14] = {8'b1000_0000, 13'b101_0_0_00_0_0_0_1_10};
        vecs[15] = {8'b0010_0000, 13'b000_0_0_00_0_0_0_0_00};

        #12;
        check("reset_outputs", outs(), 13'd0);
        rst = 1'b0;
        step(1);

        for (int i = 0; i < NV; i++) begin
            {start, cancel, fault_clear, keep_warm, extra_hot, large_size,
             temp_ready, pressure_ready} = vecs[i].in;
            step(1);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Nominal brew: 3 ms preinfuse + 8 ms brew, each +1 transition cycle.
        idle_inputs();
        start = 1;
        step(1);
        start = 0;
        check("nom_preheat_state", state_out, 3'd1);
        step(100);
        check("nom_preheat_hold", {state_out, target_temp_mode, pump_enable},
              {3'd1, 2'b01, 1'b0});
        temp_ready = 1; pressure_ready = 1;
        d0 = done_cnt;
        pcount = 0;
        brew_mode = 2'b11;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (pump_enable) begin
                pcount++;
                if (state_out == 3'd3) brew_mode = target_temp_mode;
            end
            if (state_out == 3'd0) break;
        end
        check("nom_pump_cycles", pcount, 112);
        check("nom_brew_mode", brew_mode, 2'b01);
        check("nom_done_pulses", done_cnt - d0, 1);
        check("nom_final_state", state_out, 3'd0);

        // Heat timeout with extra_hot.
        idle_inputs();
        extra_hot = 1;
        start = 1;
        step(1);
        start = 0;
        c0 = cyc;
        check("heat_mode_extra", {target_temp_mode, heating_enable}, {2'b10, 1'b1});
        wait_state(3'd5, 700, ok);
        check("heat_fault_reached", ok, 1);
        check("heat_fault_time", cyc - c0, 501);
        check("heat_fault_outs", {fault, fault_code, heating_enable, pump_enable},
              {1'b1, 2'b01, 1'b0, 1'b0});
        clear_fault();
        check("heat_clear", {state_out, fault_code, fault}, {3'd0, 2'b00, 1'b0});

        // Pressure loss at ms 5 of BREW.
        idle_inputs();
        go_brew(1'b0);
        step(50);
        pressure_ready = 0;
        d0 = done_cnt;
        step(1);
        check("ploss_outs", {state_out, pump_enable, fault_code},
              {3'd5, 1'b0, 2'b10});
        check("ploss_no_done", done_cnt - d0, 0);
        clear_fault();

        // Temp-drop tolerance: two 3 ms dips, large brew completes.
        idle_inputs();
        go_brew(1'b1);
        c0 = cyc;
        step(10);
        temp_ready = 0;
        step(30);
        temp_ready = 1;
        step(20);
        temp_ready = 0;
        step(30);
        temp_ready = 1;
        wait_state(3'd4, 100, ok);
        check("tdrop_complete", ok, 1);
        check("tdrop_brew_len", cyc - c0, 121);
        check("tdrop_done", done, 1'b1);
        step(1);
        check("tdrop_idle", state_out, 3'd0);

        // Temp held low for 4 ms faults.
        idle_inputs();
        go_brew(1'b0);
        c0 = cyc;
        step(10);
        temp_ready = 0;
        wait_state(3'd5, 100, ok);
        check("tdrop_fault", ok, 1);
        check("tdrop_fault_code", fault_code, 2'b11);
        check("tdrop_fault_time", cyc - c0, 51);
        clear_fault();

        // Cancel during pre-infusion.
        idle_inputs();
        temp_ready = 1; pressure_ready = 1;
        start = 1;
        step(1);
        start = 0;
        step(6);
        check("cancel_in_preinfuse", state_out, 3'd2);
        d0 = done_cnt;
        cancel = 1;
        step(1);
        cancel = 0;
        check("cancel_outs", {state_out, pump_enable, done, fault},
              {3'd0, 1'b0, 1'b0, 1'b0});
        check("cancel_no_done", done_cnt - d0, 0);

        // Pressure loss on the same cycle as brew expiry.
        idle_inputs();
        go_brew(1'b0);
        d0 = done_cnt;
        step(80);
        pressure_ready = 0;
        step(1);
        check("collide_fault", {state_out, fault_code}, {3'd5, 2'b10});
        check("collide_no_done", done_cnt - d0, 0);
        clear_fault();

        // Asynchronous reset mid-brew.
        idle_inputs();
        go_brew(1'b0);
        step(20);
        #3;
        rst = 1;
        #1;
        check("async_rst_outs", outs(), 13'd0);
        rst = 0;
        keep_warm = 1;
        step(1);
        check("post_rst_warm", {state_out, heating_enable, target_temp_mode},
              {3'd0, 1'b1, 2'b00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
